// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB3 bus bundle for apb_master_bridge.
// master: bridge side (drives cmd_ready, rsp_*, P* outputs); slave: the other side.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: one command at a time -> SETUP/ACCESS transfer -> held response.
// Ports: i_pclk, i_preset (async active-high), io_bus (cmd, rsp and APB signals).
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_pclk,
  input  logic                 i_preset,
  apb_master_bridge_if.master  io_bus
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                  r_psel, w_psel_nxt;
  logic                  r_pen, w_pen_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic                  r_rerr, w_rerr_nxt;
  logic                  r_rto, w_rto_nxt;
  logic                  w_cmd_ready;
  logic                  w_accept;

  // No new command while a response is still outstanding.
  assign w_cmd_ready = (r_state == IDLE) && !r_rvalid && !i_preset;
  assign w_accept    = w_cmd_ready && io_bus.cmd_valid;
  assign w_cnt_inc   = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_psel_nxt   = r_psel;
    w_pen_nxt    = r_pen;
    w_pwrite_nxt = r_pwrite;
    w_paddr_nxt  = r_paddr;
    w_pwdata_nxt = r_pwdata;
    w_rvalid_nxt = r_rvalid;
    w_rdata_nxt  = r_rdata;
    w_rerr_nxt   = r_rerr;
    w_rto_nxt    = r_rto;
    if (r_rvalid && io_bus.rsp_ready)
      w_rvalid_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = SETUP;
          w_psel_nxt   = 1'b1;
          w_pen_nxt    = 1'b0;
          w_pwrite_nxt = io_bus.cmd_write;
          w_paddr_nxt  = io_bus.cmd_addr;
          w_pwdata_nxt = io_bus.cmd_write ?
                         io_bus.cmd_wdata : '0;
        end
      end
      SETUP: begin
        w_state_nxt = ACCESS;
        w_pen_nxt   = 1'b1;
        w_cnt_nxt   = '0;
      end
      ACCESS: begin
        if (io_bus.PREADY) begin
          w_state_nxt  = IDLE;
          w_psel_nxt   = 1'b0;
          w_pen_nxt    = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = r_pwrite ? '0 : io_bus.PRDATA;
          w_rerr_nxt   = io_bus.PSLVERR;
          w_rto_nxt    = 1'b0;
        end else if (TIMEOUT_CYCLES > 0 &&
                     w_cnt_inc == TO_LIMIT) begin
          // Abort on the last allowed wait cycle.
          w_state_nxt  = IDLE;
          w_psel_nxt   = 1'b0;
          w_pen_nxt    = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = '0;
          w_rerr_nxt   = 1'b1;
          w_rto_nxt    = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_psel_nxt  = 1'b0;
        w_pen_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_psel   <= 1'b0;
      r_pen    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
      r_rto    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_psel   <= w_psel_nxt;
      r_pen    <= w_pen_nxt;
      r_pwrite <= w_pwrite_nxt;
      r_paddr  <= w_paddr_nxt;
      r_pwdata <= w_pwdata_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rerr   <= w_rerr_nxt;
      r_rto    <= w_rto_nxt;
    end
  end

  assign io_bus.cmd_ready   = w_cmd_ready;
  assign io_bus.PSELx       = r_psel;
  assign io_bus.PENABLE     = r_pen;
  assign io_bus.PWRITE      = r_pwrite;
  assign io_bus.PADDR       = r_paddr;
  assign io_bus.PWDATA      = r_pwdata;
  assign io_bus.rsp_valid   = r_rvalid;
  assign io_bus.rsp_rdata   = r_rdata;
  assign io_bus.rsp_err     = r_rerr;
  assign io_bus.rsp_timeout = r_rto;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge.
// Includes a wait-state APB slave and a transaction-level reference model.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int MEM_DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_pclk   (clk),
    .i_preset (rst),
    .io_bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // APB slave: memory with configurable wait states or stuck PREADY.
  logic [DW-1:0] smem [MEM_DEPTH];
  int s_wait = 0;
  bit s_stuck = 1'b0;
  int s_cnt = 0;
  logic s_acc;
  logic s_inr;

  assign s_acc = bus.PSELx && bus.PENABLE;
  assign s_inr = bus.PADDR < MEM_DEPTH;

  always_comb begin
    bus.PREADY  = s_acc && !s_stuck && (s_cnt >= s_wait);
    bus.PSLVERR = s_acc && !s_inr;
    bus.PRDATA  = '0;
    if (s_acc && !bus.PWRITE && s_inr)
      bus.PRDATA = smem[bus.PADDR[7:0]];
  end

  always @(posedge clk) begin
    if (s_acc) begin
      if (bus.PREADY) begin
        if (bus.PWRITE && s_inr)
          smem[bus.PADDR[7:0]] <= bus.PWDATA;
        s_cnt <= 0;
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else begin
      s_cnt <= 0;
    end
  end

  // Reference model: the memory contents seen by completed transfers.
  logic [DW-1:0] ref_mem [MEM_DEPTH];

  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int waits,
                         input bit stuck, input bit hold);
    bit e_err, e_to, ok;
    logic [DW-1:0] e_rd;
    int e_lat, n;
    if (stuck) begin
      e_to = 1'b1; e_err = 1'b1; e_rd = '0; e_lat = 1 + TO;
    end else begin
      e_to  = 1'b0;
      e_err = (addr >= MEM_DEPTH);
      e_lat = 2 + waits;
      e_rd  = '0;
      if (!wr && !e_err) e_rd = ref_mem[addr[7:0]];
      if (wr && !e_err) ref_mem[addr[7:0]] = wd;
    end
    @(negedge clk);
    s_wait = waits;
    s_stuck = stuck;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
    chk("setup", {bus.PSELx, bus.PENABLE}, 2'b10);
    chk("pwdata", bus.PWDATA, wr ? wd : '0);
    n = 0;
    ok = 1'b1;
    while (!bus.rsp_valid && n < 64) begin
      if (bus.PADDR !== addr || bus.PWRITE !== wr) ok = 1'b0;
      if (n >= 1 && bus.PENABLE !== 1'b1) ok = 1'b0;
      if (bus.PSELx !== 1'b1) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", n, e_lat);
    chk("stable", ok, 1);
    chk("rdata", bus.rsp_rdata, e_rd);
    chk("err", bus.rsp_err, e_err);
    chk("timeout", bus.rsp_timeout, e_to);
    chk("psel_idle", {bus.PSELx, bus.PENABLE}, 2'b00);
    if (hold) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      ok = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1) ok = 1'b0;
        if (bus.rsp_rdata !== e_rd || bus.rsp_err !== e_err) ok = 1'b0;
        if (bus.PSELx !== 1'b0) ok = 1'b0;
      end
      chk("hold", ok, 1);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    s_stuck = 1'b0;
    chk("consumed", bus.rsp_valid, 0);
    chk("data_held", bus.rsp_rdata, e_rd);
    chk("ready_again", bus.cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      smem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE}, 3'b000);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b000);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_ready", bus.cmd_ready, 1);

    run_cmd(1'b1, 32'd10, 8'hAA, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 32'd11, 8'h55, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 32'd12, 8'hF0, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'd10, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'd11, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'd12, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(1'b0, MEM_DEPTH + 5, 8'h00, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 32'h3C, 8'h9D, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h3C, 8'h00, 3, 1'b0, 1'b0);
    run_cmd(1'b0, 32'd11, 8'h00, 0, 1'b1, 1'b0);
    run_cmd(1'b0, 32'd12, 8'h00, 0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = ($urandom % 8 == 0) ? AW'(MEM_DEPTH + $urandom % 16)
                              : AW'(8 + $urandom % 8);
      run_cmd(1'($urandom % 2), a, 8'($urandom),
              int'($urandom % 4), ($urandom % 12 == 0),
              ($urandom % 4 == 0));
    end

    // Reset during ACCESS drops the transfer with no response.
    @(negedge clk);
    s_stuck = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_access", {bus.PSELx, bus.PENABLE}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_drop", {bus.PSELx, bus.PENABLE}, 2'b00);
    chk("rst_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    s_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_rsp", bus.rsp_valid, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);
    run_cmd(1'b0, 32'd10, 8'h00, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
